dma_regs: RTL and testbench
===========================

Name: dma_regs

Overview:
- Host-facing Wishbone slave register file that sits directly upstream of the DMA descriptor controller.
- Holds the enable, resume and interrupt-enable control bits and the next-descriptor address (NDAR) with its dirty flag.
- Produces the one-cycle interrupt-clear pulse for the controller.
- Returns controller status (busy, state, DAR, descriptor control words, next descriptor) and gates the controller interrupt to the host IRQ line.

Parameters:
- VERSION_ID, 32'h0001_0000, value returned by the read-only ID register.

Ports:
- wb_clk_i  in  1  single clock
- wb_rst_n_i  in  1  reset, asynchronous, active-low
- wbs_cyc_i  in  1  WB cycle
- wbs_stb_i  in  1  WB strobe
- wbs_we_i  in  1  WB write enable
- wbs_sel_i  in  4  WB byte selects
- wbs_adr_i  in  5  WB word address, byte address bits [6:2]
- wbs_dat_i  in  32  WB write data
- wbs_dat_o  out  32  WB read data
- wbs_ack_o  out  1  WB acknowledge
- wbs_err_o  out  1  WB error
- enable  out  1  controller enable
- resume  out  1  resume request
- resume_clear  in  1  controller consumed resume
- ndar  out  29  next descriptor address [31:3]
- ndar_dirty  out  1  NDAR written, not yet consumed
- ndar_dirty_clear  in  1  controller consumed NDAR
- wb_int_clear  out  1  one-cycle interrupt clear pulse
- wb_int_o  in  1  controller interrupt status
- busy  in  1  controller busy
- ctrl_state  in  8  controller state (debug)
- dar  in  32  current descriptor address
- dc0  in  24  control word, descriptor 0
- dc1  in  24  control word, descriptor 1
- next_desc  in  29  next descriptor pointer
- irq_o  out  1  host interrupt

Behaviour:
- Reset (wb_rst_n_i low, asynchronous): all registers and outputs are 0; wbs_dat_o is 0.
- Bus handshake:
  - Access = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & ~wbs_err_o.
  - Response is registered, 1 cycle after the access is sampled, held high for exactly 1 cycle.
  - A held strobe produces responses every other cycle.
  - Mapped address -> wbs_ack_o; unmapped address -> wbs_err_o, no side effects.
- Read data is registered, valid in the ack cycle.
- Writes take effect on the access clock edge, qualified per byte by wbs_sel_i. Writes to read-only fields are acked and ignored.
- Register map (byte offset):
  - 0x00 CSR:
    - [0] enable, RW.
    - [1] resume, write 1 sets, write 0 no effect; reads the current flag.
    - [2] busy, RO.
    - [3] wb_int_o, RO.
    - [4] write 1 pulses wb_int_clear for 1 cycle; reads 0.
    - [5] int_en, RW.
    - [15:8] ctrl_state, RO.
    - Other bits read 0.
  - 0x04 NDAR: [31:3] RW, [2:0] read 0. Any write with sel != 0 sets ndar_dirty on the next cycle.
  - 0x08 DAR, RO.
  - 0x0C DC0, RO, zero-extended.
  - 0x10 DC1, RO, zero-extended.
  - 0x14 NEXT_DESC, RO, as {next_desc, 3'b0}.
  - 0x18 ID, RO, value VERSION_ID.
  - 0x1C–0x7C: unmapped -> err.
- ndar_dirty:
  - Set by an NDAR write; cleared by ndar_dirty_clear.
  - If both occur in the same cycle, set wins, so a new address is never lost.
- resume:
  - Set by a CSR write with bit1 = 1; cleared by resume_clear.
  - If both occur in the same cycle, set wins.
- wb_int_clear: registered, asserted in the cycle after the CSR write access, exactly 1 cycle wide.
- irq_o = wb_int_o & int_en, combinational.
- Clearing enable while busy does not abort the controller. It only blocks new starts, which is controller behaviour.
- Reset mid-transaction: ack/err drop immediately; the pending access is lost and no write takes effect.

Decomposition:
- Shared package constants:
  - register offsets REG_CSR, REG_NDAR, REG_DAR, REG_DC0, REG_DC1, REG_NEXT, REG_ID;
  - CSR bit indices CSR_EN, CSR_RESUME, CSR_BUSY, CSR_INT, CSR_INTCLR, CSR_INTEN;
  - the state field position.
- Natural sub-module: dma_regs_flag, a set/clear flag register with set-priority, instanced for ndar_dirty and resume.

Test Plan:
- Reset, then read 0x00 -> ack 1 cycle later, data 0x0000_0000; enable = 0, ndar_dirty = 0, irq_o = 0.
- Write 0x04 = 0x1234_5678 -> ndar = 0x1234_5678 >> 3; read back 0x1234_5678; ndar_dirty = 1 until a ndar_dirty_clear pulse, then 0.
- Write NDAR in the same cycle ndar_dirty_clear is high -> ndar_dirty stays 1 with the new value.
- Write CSR = 0x23 -> enable = 1, int_en = 1, resume = 1; resume_clear pulse -> resume = 0. With wb_int_o = 1, irq_o = 1. Write CSR = 0x31 -> one-cycle wb_int_clear.
- Drive busy = 1, ctrl_state = 8'h06, dar = 0x8000_0040, dc0 = 24'h00C080. Reads give CSR = 0x0000_0604 (with enable/int_en 0), DAR = 0x8000_0040, DC0 = 0x0000_C080; ID = 0x0001_0000.
- Access 0x20 -> wbs_err_o for 1 cycle, no ack, no state change. Byte write sel = 4'b0001 of 0xFFFF_FFFF to NDAR -> only [7:3] change.

Source files
------------

// File: rtl/dma_regs_pkg.sv
// Shared register map and CSR bit layout for the DMA host register file.
package dma_regs_pkg;

  localparam logic [6:0] REG_CSR  = 7'h00;
  localparam logic [6:0] REG_NDAR = 7'h04;
  localparam logic [6:0] REG_DAR  = 7'h08;
  localparam logic [6:0] REG_DC0  = 7'h0C;
  localparam logic [6:0] REG_DC1  = 7'h10;
  localparam logic [6:0] REG_NEXT = 7'h14;
  localparam logic [6:0] REG_ID   = 7'h18;

  localparam int CSR_EN        = 0;
  localparam int CSR_RESUME    = 1;
  localparam int CSR_BUSY      = 2;
  localparam int CSR_INT       = 3;
  localparam int CSR_INTCLR    = 4;
  localparam int CSR_INTEN     = 5;
  localparam int CSR_STATE_LSB = 8;
  localparam int CSR_STATE_W   = 8;

  // The map is dense from CSR up to ID; everything above it errors.
  function automatic logic is_mapped(input logic [6:0] byte_adr);
    return byte_adr <= REG_ID;
  endfunction

endpackage

// File: rtl/dma_regs_if.sv
// Wishbone slave bus bundle between the host and the DMA register file.
interface dma_regs_if;

  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [4:0]  wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        wbs_err_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o
  );

endinterface

// File: rtl/dma_regs_flag.sv
// Sticky flag with set priority, so a new request is never lost to a same-cycle clear.
module dma_regs_flag (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic clr,
  output logic q
);

  logic flag_d;
  logic flag_q;

  always_comb begin
    flag_d = flag_q;
    if (set)      flag_d = 1'b1;
    else if (clr) flag_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flag_q <= 1'b0;
    else        flag_q <= flag_d;
  end

  assign q = flag_q;

endmodule

// File: rtl/dma_regs.sv
// Host-facing Wishbone register file for the DMA descriptor controller: control bits,
// NDAR with dirty tracking, interrupt-clear pulse and controller status readback.
module dma_regs
  import dma_regs_pkg::*;
#(
  parameter logic [31:0] VERSION_ID = 32'h0001_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  dma_regs_if.slave   wbs,
  output logic        enable,
  output logic        resume,
  input  logic        resume_clear,
  output logic [28:0] ndar,
  output logic        ndar_dirty,
  input  logic        ndar_dirty_clear,
  output logic        wb_int_clear,
  input  logic        wb_int_o,
  input  logic        busy,
  input  logic [7:0]  ctrl_state,
  input  logic [31:0] dar,
  input  logic [23:0] dc0,
  input  logic [23:0] dc1,
  input  logic [28:0] next_desc,
  output logic        irq_o
);

  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] dat_q, dat_d;
  logic        enable_q, enable_d;
  logic        int_en_q, int_en_d;
  logic        int_clr_q, int_clr_d;
  logic [28:0] ndar_q, ndar_d;

  logic        access;
  logic        mapped;
  logic [6:0]  byte_adr;
  logic        wr_csr;
  logic        wr_ndar;
  logic        resume_set;
  logic        dirty_set;
  logic [31:0] rdata;

  // A response in flight blocks re-sampling, so a held strobe is served every other cycle.
  always_comb begin
    byte_adr   = {wbs.wbs_adr_i, 2'b00};
    access     = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q & ~err_q;
    mapped     = is_mapped(byte_adr);
    wr_csr     = access & wbs.wbs_we_i & (byte_adr == REG_CSR);
    wr_ndar    = access & wbs.wbs_we_i & (byte_adr == REG_NDAR);
    resume_set = wr_csr & wbs.wbs_sel_i[0] & wbs.wbs_dat_i[CSR_RESUME];
    dirty_set  = wr_ndar & (|wbs.wbs_sel_i);
  end

  always_comb begin
    rdata = '0;
    case (byte_adr)
      REG_CSR: begin
        rdata[CSR_EN]     = enable_q;
        rdata[CSR_RESUME] = resume;
        rdata[CSR_BUSY]   = busy;
        rdata[CSR_INT]    = wb_int_o;
        rdata[CSR_INTEN]  = int_en_q;
        rdata[CSR_STATE_LSB +: CSR_STATE_W] = ctrl_state;
      end
      REG_NDAR: rdata = {ndar_q, 3'b000};
      REG_DAR:  rdata = dar;
      REG_DC0:  rdata = {8'h00, dc0};
      REG_DC1:  rdata = {8'h00, dc1};
      REG_NEXT: rdata = {next_desc, 3'b000};
      REG_ID:   rdata = VERSION_ID;
      default:  rdata = '0;
    endcase
  end

  // NDAR bit 0 is address bit 3, so byte lane 0 only carries five writable bits.
  always_comb begin
    ack_d     = access & mapped;
    err_d     = access & ~mapped;
    dat_d     = (access & mapped & ~wbs.wbs_we_i) ? rdata : '0;
    enable_d  = enable_q;
    int_en_d  = int_en_q;
    int_clr_d = wr_csr & wbs.wbs_sel_i[0] & wbs.wbs_dat_i[CSR_INTCLR];
    ndar_d    = ndar_q;
    if (wr_csr && wbs.wbs_sel_i[0]) begin
      enable_d = wbs.wbs_dat_i[CSR_EN];
      int_en_d = wbs.wbs_dat_i[CSR_INTEN];
    end
    if (wr_ndar) begin
      if (wbs.wbs_sel_i[0]) ndar_d[4:0]   = wbs.wbs_dat_i[7:3];
      if (wbs.wbs_sel_i[1]) ndar_d[12:5]  = wbs.wbs_dat_i[15:8];
      if (wbs.wbs_sel_i[2]) ndar_d[20:13] = wbs.wbs_dat_i[23:16];
      if (wbs.wbs_sel_i[3]) ndar_d[28:21] = wbs.wbs_dat_i[31:24];
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_q     <= '0;
      enable_q  <= 1'b0;
      int_en_q  <= 1'b0;
      int_clr_q <= 1'b0;
      ndar_q    <= '0;
    end else begin
      ack_q     <= ack_d;
      err_q     <= err_d;
      dat_q     <= dat_d;
      enable_q  <= enable_d;
      int_en_q  <= int_en_d;
      int_clr_q <= int_clr_d;
      ndar_q    <= ndar_d;
    end
  end

  dma_regs_flag u_resume_flag (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n_i),
    .set   (resume_set),
    .clr   (resume_clear),
    .q     (resume)
  );

  dma_regs_flag u_ndar_dirty_flag (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n_i),
    .set   (dirty_set),
    .clr   (ndar_dirty_clear),
    .q     (ndar_dirty)
  );

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_err_o = err_q;
  assign wbs.wbs_dat_o = dat_q;
  assign enable        = enable_q;
  assign ndar          = ndar_q;
  assign wb_int_clear  = int_clr_q;
  assign irq_o         = wb_int_o & int_en_q;

endmodule

// File: tb/tb_dma_regs.sv
// Scoreboard bench for dma_regs: bus responses are queued at issue time and checked by a
// separate monitor; sideband outputs are checked directly against hand-computed values.
module tb_dma_regs;

  typedef struct packed {
    logic        is_err;
    logic        is_read;
    logic [31:0] data;
  } exp_t;

  logic        wb_clk_i;
  logic        wb_rst_n_i;
  logic        enable;
  logic        resume;
  logic        resume_clear;
  logic [28:0] ndar;
  logic        ndar_dirty;
  logic        ndar_dirty_clear;
  logic        wb_int_clear;
  logic        wb_int_o;
  logic        busy;
  logic [7:0]  ctrl_state;
  logic [31:0] dar;
  logic [23:0] dc0;
  logic [23:0] dc1;
  logic [28:0] next_desc;
  logic        irq_o;

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];

  dma_regs_if wbs();

  dma_regs #(.VERSION_ID(32'h0001_0000)) dut (
    .wb_clk_i         (wb_clk_i),
    .wb_rst_n_i       (wb_rst_n_i),
    .wbs              (wbs.slave),
    .enable           (enable),
    .resume           (resume),
    .resume_clear     (resume_clear),
    .ndar             (ndar),
    .ndar_dirty       (ndar_dirty),
    .ndar_dirty_clear (ndar_dirty_clear),
    .wb_int_clear     (wb_int_clear),
    .wb_int_o         (wb_int_o),
    .busy             (busy),
    .ctrl_state       (ctrl_state),
    .dar              (dar),
    .dc0              (dc0),
    .dc1              (dc1),
    .next_desc        (next_desc),
    .irq_o            (irq_o)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // One bus access; the expected response is queued before the strobe goes out.
  task automatic applyStimulus(input logic we, input logic [4:0] adr, input logic [3:0] sel,
                               input logic [31:0] dat, input logic exp_err,
                               input logic [31:0] exp_data);
    exp_t e;
    logic got;
    @(negedge wb_clk_i);
    e.is_err  = exp_err;
    e.is_read = ~we & ~exp_err;
    e.data    = exp_data;
    sb_q.push_back(e);
    wbs.wbs_cyc_i = 1'b1;
    wbs.wbs_stb_i = 1'b1;
    wbs.wbs_we_i  = we;
    wbs.wbs_adr_i = adr;
    wbs.wbs_sel_i = sel;
    wbs.wbs_dat_i = dat;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge wb_clk_i);
      #1;
      got = wbs.wbs_ack_o | wbs.wbs_err_o;
    end
    wbs.wbs_cyc_i = 1'b0;
    wbs.wbs_stb_i = 1'b0;
    wbs.wbs_we_i  = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL bus_timeout: adr 0x%02h got no response, expected ack or err", adr);
      void'(sb_q.pop_back());
    end
  endtask

  // Monitor: every presented response is matched against the oldest expectation.
  always @(negedge wb_clk_i) begin
    exp_t e;
    if (wb_rst_n_i && (wbs.wbs_ack_o || wbs.wbs_err_o)) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rsp: got ack=%0b err=%0b, expected none",
                 wbs.wbs_ack_o, wbs.wbs_err_o);
      end else begin
        e = sb_q.pop_front();
        checkOutput("rsp_err", {31'b0, wbs.wbs_err_o}, {31'b0, e.is_err});
        checkOutput("rsp_ack", {31'b0, wbs.wbs_ack_o}, {31'b0, ~e.is_err});
        if (e.is_read) checkOutput("rdata", wbs.wbs_dat_o, e.data);
      end
    end
  end

  task automatic pulseClear(input logic dirty_not_resume);
    @(negedge wb_clk_i);
    if (dirty_not_resume) ndar_dirty_clear = 1'b1;
    else                  resume_clear     = 1'b1;
    @(posedge wb_clk_i);
    #1;
    ndar_dirty_clear = 1'b0;
    resume_clear     = 1'b0;
  endtask

  initial begin
    exp_t e;
    wb_rst_n_i = 1'b0;
    wbs.wbs_cyc_i = 1'b0;
    wbs.wbs_stb_i = 1'b0;
    wbs.wbs_we_i  = 1'b0;
    wbs.wbs_sel_i = 4'h0;
    wbs.wbs_adr_i = 5'h00;
    wbs.wbs_dat_i = 32'h0;
    resume_clear = 1'b0;
    ndar_dirty_clear = 1'b0;
    wb_int_o   = 1'b0;
    busy       = 1'b0;
    ctrl_state = 8'h00;
    dar        = 32'h0;
    dc0        = 24'h0;
    dc1        = 24'h0;
    next_desc  = 29'h0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    checkOutput("rst_ack", {31'b0, wbs.wbs_ack_o}, 32'h0);
    checkOutput("rst_err", {31'b0, wbs.wbs_err_o}, 32'h0);
    checkOutput("rst_dat", wbs.wbs_dat_o, 32'h0);
    checkOutput("rst_enable", {31'b0, enable}, 32'h0);
    checkOutput("rst_resume", {31'b0, resume}, 32'h0);
    checkOutput("rst_ndar", {3'b0, ndar}, 32'h0);
    checkOutput("rst_dirty", {31'b0, ndar_dirty}, 32'h0);
    checkOutput("rst_intclr", {31'b0, wb_int_clear}, 32'h0);
    checkOutput("rst_irq", {31'b0, irq_o}, 32'h0);
    @(negedge wb_clk_i);
    wb_rst_n_i = 1'b1;

    applyStimulus(1'b0, 5'h00, 4'hF, 32'h0, 1'b0, 32'h0000_0000);

    // NDAR write, readback and dirty handshake
    applyStimulus(1'b1, 5'h01, 4'hF, 32'h1234_5678, 1'b0, 32'h0);
    checkOutput("ndar_full", {3'b0, ndar}, 32'h0246_8ACF);
    checkOutput("dirty_set", {31'b0, ndar_dirty}, 32'h1);
    applyStimulus(1'b0, 5'h01, 4'hF, 32'h0, 1'b0, 32'h1234_5678);
    checkOutput("dirty_held", {31'b0, ndar_dirty}, 32'h1);
    pulseClear(1'b1);
    checkOutput("dirty_cleared", {31'b0, ndar_dirty}, 32'h0);

    ndar_dirty_clear = 1'b1;
    applyStimulus(1'b1, 5'h01, 4'hF, 32'hCAFE_BABE, 1'b0, 32'h0);
    ndar_dirty_clear = 1'b0;
    checkOutput("dirty_set_wins", {31'b0, ndar_dirty}, 32'h1);
    checkOutput("ndar_new", {ndar, 3'b000}, 32'hCAFE_BAB8);
    applyStimulus(1'b0, 5'h01, 4'hF, 32'h0, 1'b0, 32'hCAFE_BAB8);

    // CSR control bits, resume handshake, interrupt gating
    applyStimulus(1'b1, 5'h00, 4'h1, 32'h0000_0023, 1'b0, 32'h0);
    checkOutput("csr_enable", {31'b0, enable}, 32'h1);
    checkOutput("csr_resume", {31'b0, resume}, 32'h1);
    checkOutput("csr_no_intclr", {31'b0, wb_int_clear}, 32'h0);
    pulseClear(1'b0);
    checkOutput("resume_cleared", {31'b0, resume}, 32'h0);
    wb_int_o = 1'b1;
    #1;
    checkOutput("irq_on", {31'b0, irq_o}, 32'h1);
    applyStimulus(1'b0, 5'h00, 4'hF, 32'h0, 1'b0, 32'h0000_0029);
    applyStimulus(1'b1, 5'h00, 4'h1, 32'h0000_0031, 1'b0, 32'h0);
    checkOutput("intclr_pulse", {31'b0, wb_int_clear}, 32'h1);
    checkOutput("resume_w0", {31'b0, resume}, 32'h0);
    @(posedge wb_clk_i);
    #1;
    checkOutput("intclr_one_cycle", {31'b0, wb_int_clear}, 32'h0);

    resume_clear = 1'b1;
    applyStimulus(1'b1, 5'h00, 4'h1, 32'h0000_0023, 1'b0, 32'h0);
    resume_clear = 1'b0;
    checkOutput("resume_set_wins", {31'b0, resume}, 32'h1);
    applyStimulus(1'b1, 5'h00, 4'h1, 32'h0000_0021, 1'b0, 32'h0);
    checkOutput("resume_write0_keeps", {31'b0, resume}, 32'h1);
    pulseClear(1'b0);
    applyStimulus(1'b1, 5'h00, 4'h1, 32'h0000_0000, 1'b0, 32'h0);
    #1;
    checkOutput("irq_gated", {31'b0, irq_o}, 32'h0);
    checkOutput("enable_off", {31'b0, enable}, 32'h0);
    wb_int_o = 1'b0;

    // Status readback
    busy       = 1'b1;
    ctrl_state = 8'h06;
    dar        = 32'h8000_0040;
    dc0        = 24'h00C080;
    dc1        = 24'hABCDEF;
    next_desc  = 29'h1000_0001;
    applyStimulus(1'b0, 5'h00, 4'hF, 32'h0, 1'b0, 32'h0000_0604);
    applyStimulus(1'b0, 5'h02, 4'hF, 32'h0, 1'b0, 32'h8000_0040);
    applyStimulus(1'b0, 5'h03, 4'hF, 32'h0, 1'b0, 32'h0000_C080);
    applyStimulus(1'b0, 5'h04, 4'hF, 32'h0, 1'b0, 32'h00AB_CDEF);
    applyStimulus(1'b0, 5'h05, 4'hF, 32'h0, 1'b0, 32'h8000_0008);
    applyStimulus(1'b0, 5'h06, 4'hF, 32'h0, 1'b0, 32'h0001_0000);
    applyStimulus(1'b1, 5'h02, 4'hF, 32'h1111_1111, 1'b0, 32'h0);
    applyStimulus(1'b0, 5'h02, 4'hF, 32'h0, 1'b0, 32'h8000_0040);

    // Unmapped accesses error out with no side effects
    applyStimulus(1'b1, 5'h08, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0);
    applyStimulus(1'b0, 5'h1F, 4'hF, 32'h0, 1'b1, 32'h0);
    checkOutput("err_no_enable", {31'b0, enable}, 32'h0);
    applyStimulus(1'b0, 5'h01, 4'hF, 32'h0, 1'b0, 32'hCAFE_BAB8);

    // Byte-lane 0 write to NDAR only touches address bits [7:3]
    applyStimulus(1'b1, 5'h01, 4'h1, 32'hFFFF_FFFF, 1'b0, 32'h0);
    checkOutput("ndar_byte0", {ndar, 3'b000}, 32'hCAFE_BAF8);
    applyStimulus(1'b0, 5'h01, 4'hF, 32'h0, 1'b0, 32'hCAFE_BAF8);

    // Held strobe for four edges yields exactly two responses
    @(negedge wb_clk_i);
    e.is_err  = 1'b0;
    e.is_read = 1'b1;
    e.data    = 32'h0001_0000;
    sb_q.push_back(e);
    sb_q.push_back(e);
    wbs.wbs_cyc_i = 1'b1;
    wbs.wbs_stb_i = 1'b1;
    wbs.wbs_we_i  = 1'b0;
    wbs.wbs_adr_i = 5'h06;
    repeat (4) @(posedge wb_clk_i);
    #1;
    wbs.wbs_cyc_i = 1'b0;
    wbs.wbs_stb_i = 1'b0;

    repeat (4) @(posedge wb_clk_i);
    checkOutput("sb_drained", sb_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
